// File: rtl/rx_ppe_stm_tbl1_resp.sv
// rtl/rx_ppe_stm_tbl1_resp.sv - RX PPE table-1 shared-table-memory responder
// Banked entry storage with one write port and N_PORTS-1 read ports, fixed read latency.
module rx_ppe_stm_tbl1_resp #(
    parameter int N_BANKS  = 16,
    parameter int N_PORTS  = 5,
    parameter int N_CHUNKS = 4,
    parameter int CHUNK_W  = 72,
    parameter int ADDR_W   = 11,
    parameter int DEPTH    = 2048,
    parameter int RD_LAT   = 2
) (
    input  logic                                    cclk,
    input  logic                                    rst_n,
    input  logic [N_BANKS*3-1:0]                    tbl1_sel,
    input  logic [N_CHUNKS-1:0]                     tbl1_wen,
    input  logic [(N_PORTS-1)*N_CHUNKS-1:0]         tbl1_ren,
    input  logic [N_PORTS*ADDR_W-1:0]               tbl1_addr,
    input  logic [N_CHUNKS*CHUNK_W-1:0]             tbl1_wdata,
    output logic [(N_PORTS-1)*N_CHUNKS*CHUNK_W-1:0] tbl1_rdata,
    output logic                                    rd_conflict,
    output logic [15:0]                             rd_conflict_cnt,
    output logic                                    addr_oor
);
    localparam int ENTRY_W = N_CHUNKS * CHUNK_W;
    localparam int N_RD    = N_PORTS - 1;
    localparam int PORT_W  = (N_RD > 1) ? $clog2(N_RD) : 1;
    localparam int IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

    logic [N_PORTS-1:0] port_oor;
    for (genvar p = 0; p < N_PORTS; p++) begin : g_oor
        assign port_oor[p] = {1'b0, tbl1_addr[p*ADDR_W +: ADDR_W]} >= DEPTH_L;
    end

    logic [N_BANKS-1:0]  bank_wr;
    logic [N_BANKS-1:0]  bank_rd;
    logic [PORT_W-1:0]   bank_port  [N_BANKS];
    logic [N_CHUNKS-1:0] bank_mask  [N_BANKS];
    logic [IDX_W-1:0]    bank_raddr [N_BANKS];
    logic [N_RD-1:0]     port_seen;
    logic                conflict_any;
    logic                oor_any;
    logic [IDX_W-1:0]    waddr_idx;

    assign waddr_idx = tbl1_addr[IDX_W-1:0];

    // Decode each bank's select into a write, a read on one port, or nothing.
    always_comb begin
        logic [2:0] sel_b;
        int         rp;
        sel_b        = '0;
        rp           = 0;
        conflict_any = 1'b0;
        oor_any      = 1'b0;
        port_seen    = '0;
        for (int b = 0; b < N_BANKS; b++) begin
            bank_wr[b]    = 1'b0;
            bank_rd[b]    = 1'b0;
            bank_port[b]  = '0;
            bank_mask[b]  = '0;
            bank_raddr[b] = '0;
            sel_b = tbl1_sel[b*3 +: 3];
            if (sel_b == 3'd0) begin
                if (tbl1_wen != '0) begin
                    if (port_oor[0]) oor_any = 1'b1;
                    else             bank_wr[b] = 1'b1;
                end
            end else if (int'(sel_b) <= N_RD) begin
                rp = int'(sel_b) - 1;
                if (tbl1_ren[rp*N_CHUNKS +: N_CHUNKS] != '0) begin
                    if (port_seen[rp]) conflict_any = 1'b1;
                    port_seen[rp] = 1'b1;
                    if (port_oor[rp+1]) begin
                        oor_any = 1'b1;
                    end else begin
                        bank_rd[b]    = 1'b1;
                        bank_port[b]  = PORT_W'(rp);
                        bank_mask[b]  = tbl1_ren[rp*N_CHUNKS +: N_CHUNKS];
                        bank_raddr[b] = tbl1_addr[(rp+1)*ADDR_W +: IDX_W];
                    end
                end
            end
        end
    end

    logic [N_BANKS-1:0]  rd_vld_q;
    logic [PORT_W-1:0]   rd_port_q  [N_BANKS];
    logic [N_CHUNKS-1:0] rd_mask_q  [N_BANKS];
    logic [ENTRY_W-1:0]  bank_rdata [N_BANKS];

    for (genvar b = 0; b < N_BANKS; b++) begin : g_bank
        logic [CHUNK_W-1:0] mem [N_CHUNKS][DEPTH];
        logic [ENTRY_W-1:0] rd_data_q;

        // Array and read register carry no reset so they map onto plain RAM.
        always_ff @(posedge cclk) begin
            for (int c = 0; c < N_CHUNKS; c++) begin
                if (bank_wr[b] && tbl1_wen[c])
                    mem[c][waddr_idx] <= tbl1_wdata[c*CHUNK_W +: CHUNK_W];
                if (bank_rd[b])
                    rd_data_q[c*CHUNK_W +: CHUNK_W] <= mem[c][bank_raddr[b]];
            end
        end

        for (genvar c = 0; c < N_CHUNKS; c++) begin : g_chunk
            assign bank_rdata[b][c*CHUNK_W +: CHUNK_W] =
                (rd_vld_q[b] && rd_mask_q[b][c]) ? rd_data_q[c*CHUNK_W +: CHUNK_W] : '0;
        end
    end

    always_ff @(posedge cclk) begin
        if (!rst_n) begin
            rd_vld_q        <= '0;
            rd_conflict     <= 1'b0;
            addr_oor        <= 1'b0;
            rd_conflict_cnt <= '0;
            for (int b = 0; b < N_BANKS; b++) begin
                rd_port_q[b] <= '0;
                rd_mask_q[b] <= '0;
            end
        end else begin
            rd_vld_q    <= bank_rd;
            rd_conflict <= conflict_any;
            addr_oor    <= oor_any;
            for (int b = 0; b < N_BANKS; b++) begin
                rd_port_q[b] <= bank_port[b];
                rd_mask_q[b] <= bank_mask[b];
            end
            if (conflict_any && rd_conflict_cnt != 16'hFFFF)
                rd_conflict_cnt <= rd_conflict_cnt + 16'd1;
        end
    end

    // Banks that hit the same port are ORed; conflicts still return the merged data.
    logic [N_RD*ENTRY_W-1:0] port_rdata;
    always_comb begin
        port_rdata = '0;
        for (int i = 0; i < N_RD; i++) begin
            for (int b = 0; b < N_BANKS; b++) begin
                if (rd_port_q[b] == PORT_W'(i))
                    port_rdata[i*ENTRY_W +: ENTRY_W] = port_rdata[i*ENTRY_W +: ENTRY_W] | bank_rdata[b];
            end
        end
    end

    if (RD_LAT == 1) begin : g_lat1
        assign tbl1_rdata = port_rdata;
    end else begin : g_pipe
        logic [N_RD*ENTRY_W-1:0] pipe_q [RD_LAT-1];
        always_ff @(posedge cclk) begin
            if (!rst_n) begin
                for (int k = 0; k < RD_LAT-1; k++) pipe_q[k] <= '0;
            end else begin
                pipe_q[0] <= port_rdata;
                for (int k = 1; k < RD_LAT-1; k++) pipe_q[k] <= pipe_q[k-1];
            end
        end
        assign tbl1_rdata = pipe_q[RD_LAT-2];
    end

endmodule

// File: tb/tb_rx_ppe_stm_tbl1_resp.sv
// tb/tb_rx_ppe_stm_tbl1_resp.sv - directed self-checking bench for rx_ppe_stm_tbl1_resp
module tb_rx_ppe_stm_tbl1_resp;
    localparam int EW = 288;

    logic              cclk = 1'b0;
    logic              rst_n;
    logic [47:0]       tbl1_sel;
    logic [3:0]        tbl1_wen;
    logic [15:0]       tbl1_ren;
    logic [54:0]       tbl1_addr;
    logic [EW-1:0]     tbl1_wdata;
    logic [4*EW-1:0]   tbl1_rdata;
    logic              rd_conflict;
    logic [15:0]       rd_conflict_cnt;
    logic              addr_oor;

    logic [2:0]  sel  [16];
    logic [3:0]  ren  [4];
    logic [10:0] addr [5];

    int n_vec = 0;
    int n_err = 0;

    always #5 cclk = ~cclk;

    always_comb begin
        tbl1_sel  = '0;
        tbl1_ren  = '0;
        tbl1_addr = '0;
        for (int b = 0; b < 16; b++) tbl1_sel[b*3 +: 3] = sel[b];
        for (int i = 0; i < 4; i++)  tbl1_ren[i*4 +: 4] = ren[i];
        for (int p = 0; p < 5; p++)  tbl1_addr[p*11 +: 11] = addr[p];
    end

    rx_ppe_stm_tbl1_resp #(.DEPTH(1024)) dut (
        .cclk(cclk), .rst_n(rst_n), .tbl1_sel(tbl1_sel), .tbl1_wen(tbl1_wen),
        .tbl1_ren(tbl1_ren), .tbl1_addr(tbl1_addr), .tbl1_wdata(tbl1_wdata),
        .tbl1_rdata(tbl1_rdata), .rd_conflict(rd_conflict),
        .rd_conflict_cnt(rd_conflict_cnt), .addr_oor(addr_oor)
    );

    function automatic logic [EW-1:0] mk(int k);
        logic [EW-1:0] r;
        for (int w = 0; w < 9; w++)
            r[w*32 +: 32] = 32'h9E37_79B9 * (k + 1) + 32'h0101_0101 * w + 32'h1;
        return r;
    endfunction

    function automatic logic [EW-1:0] slot(int i);
        return tbl1_rdata[i*EW +: EW];
    endfunction

    task automatic cyc();
        @(posedge cclk);
        #1;
    endtask

    task automatic idle();
        for (int b = 0; b < 16; b++) sel[b] = 3'd7;
        for (int i = 0; i < 4; i++)  ren[i] = 4'h0;
        for (int p = 0; p < 5; p++)  addr[p] = 11'h0;
        tbl1_wen   = 4'h0;
        tbl1_wdata = '0;
    endtask

    task automatic do_write(int b, logic [10:0] a, logic [3:0] w, logic [EW-1:0] d);
        idle();
        sel[b] = 3'd0; addr[0] = a; tbl1_wen = w; tbl1_wdata = d;
        cyc();
        idle();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        idle();
        repeat (3) cyc();
        rst_n = 1'b1;
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL reset_rdata: got %h want 0", tbl1_rdata); end
        n_vec++; if (rd_conflict !== 1'b0) begin n_err++; $display("FAIL reset_conflict: got %b want 0", rd_conflict); end
        n_vec++; if (addr_oor !== 1'b0) begin n_err++; $display("FAIL reset_oor: got %b want 0", addr_oor); end
        n_vec++; if (rd_conflict_cnt !== 16'h0) begin n_err++; $display("FAIL reset_cnt: got %h want 0", rd_conflict_cnt); end
    endtask

    task automatic test_write_read();
        logic [EW-1:0]   a;
        logic [4*EW-1:0] exp;
        a = mk(1);
        do_write(3, 11'h010, 4'hF, a);
        sel[3] = 3'd1; ren[0] = 4'hF; addr[1] = 11'h010;
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL wr_rd_t0: got %h want 0", tbl1_rdata); end
        cyc(); idle();
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL wr_rd_t1: got %h want 0", tbl1_rdata); end
        cyc();
        exp = '0; exp[0 +: EW] = a;
        n_vec++; if (tbl1_rdata !== exp) begin n_err++; $display("FAIL wr_rd_t2: got %h want %h", tbl1_rdata, exp); end
        cyc();
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL wr_rd_t3: got %h want 0", tbl1_rdata); end
    endtask

    task automatic test_partial_write();
        logic [EW-1:0] b_pat;
        logic [EW-1:0] exp;
        b_pat = mk(2);
        do_write(4, 11'h020, 4'hF, '1);
        do_write(4, 11'h020, 4'b0101, b_pat);
        exp = '1;
        exp[0 +: 72]   = b_pat[0 +: 72];
        exp[144 +: 72] = b_pat[144 +: 72];
        sel[4] = 3'd2; ren[1] = 4'hF; addr[2] = 11'h020;
        cyc(); idle(); cyc();
        n_vec++; if (slot(1) !== exp) begin n_err++; $display("FAIL partial_wr: got %h want %h", slot(1), exp); end
        n_vec++; if (slot(0) !== '0) begin n_err++; $display("FAIL partial_other_port: got %h want 0", slot(0)); end
    endtask

    task automatic test_chunk_read();
        logic [EW-1:0] a;
        logic [EW-1:0] exp;
        a = mk(1);
        exp = '0; exp[72 +: 72] = a[72 +: 72];
        sel[3] = 3'd4; ren[3] = 4'b0010; addr[4] = 11'h010;
        cyc(); idle(); cyc();
        n_vec++; if (slot(3) !== exp) begin n_err++; $display("FAIL chunk_rd: got %h want %h", slot(3), exp); end
    endtask

    task automatic test_conflict();
        logic [EW-1:0] c_pat, d_pat;
        c_pat = mk(3);
        d_pat = mk(4);
        do_write(2, 11'h030, 4'hF, c_pat);
        do_write(5, 11'h030, 4'hF, d_pat);
        sel[2] = 3'd3; sel[5] = 3'd3; ren[2] = 4'h0; addr[3] = 11'h030;
        cyc(); idle();
        n_vec++; if (rd_conflict !== 1'b0) begin n_err++; $display("FAIL conf_ren0: got %b want 0", rd_conflict); end
        sel[2] = 3'd3; sel[5] = 3'd3; ren[2] = 4'hF; addr[3] = 11'h030;
        cyc(); idle();
        n_vec++; if (rd_conflict !== 1'b1) begin n_err++; $display("FAIL conf_pulse: got %b want 1", rd_conflict); end
        n_vec++; if (rd_conflict_cnt !== 16'd1) begin n_err++; $display("FAIL conf_cnt1: got %h want 0001", rd_conflict_cnt); end
        cyc();
        n_vec++; if (rd_conflict !== 1'b0) begin n_err++; $display("FAIL conf_pulse_end: got %b want 0", rd_conflict); end
        n_vec++; if (slot(2) !== (c_pat | d_pat)) begin n_err++; $display("FAIL conf_or: got %h want %h", slot(2), c_pat | d_pat); end
        n_vec++; if (rd_conflict_cnt !== 16'd1) begin n_err++; $display("FAIL conf_cnt_hold: got %h want 0001", rd_conflict_cnt); end
        sel[2] = 3'd3; sel[5] = 3'd3; ren[2] = 4'hF; addr[3] = 11'h030;
        repeat (65533) cyc();
        n_vec++; if (rd_conflict_cnt !== 16'hFFFE) begin n_err++; $display("FAIL conf_cnt_fffe: got %h want fffe", rd_conflict_cnt); end
        cyc();
        n_vec++; if (rd_conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL conf_cnt_ffff: got %h want ffff", rd_conflict_cnt); end
        cyc(); cyc();
        n_vec++; if (rd_conflict_cnt !== 16'hFFFF) begin n_err++; $display("FAIL conf_cnt_sat: got %h want ffff", rd_conflict_cnt); end
        n_vec++; if (rd_conflict !== 1'b1) begin n_err++; $display("FAIL conf_cont: got %b want 1", rd_conflict); end
        idle(); cyc();
        n_vec++; if (rd_conflict !== 1'b0) begin n_err++; $display("FAIL conf_stop: got %b want 0", rd_conflict); end
    endtask

    task automatic test_back_to_back();
        logic [EW-1:0] exp;
        for (int i = 0; i < 4; i++)
            for (int k = 0; k < 8; k++)
                do_write(8 + i, 11'h100 + 11'(k), 4'hF, mk(16 + i*8 + k));
        for (int t = 0; t <= 10; t++) begin
            idle();
            if (t < 8) begin
                for (int i = 0; i < 4; i++) begin
                    sel[8 + i]  = 3'(i + 1);
                    ren[i]      = 4'hF;
                    addr[i + 1] = 11'h100 + 11'((t + i) % 8);
                end
                sel[12] = 3'd0; tbl1_wen = 4'hF; addr[0] = 11'h200 + 11'(t); tbl1_wdata = mk(100 + t);
            end
            for (int i = 0; i < 4; i++) begin
                exp = (t >= 2 && t - 2 < 8) ? mk(16 + i*8 + ((t - 2 + i) % 8)) : '0;
                n_vec++;
                if (slot(i) !== exp) begin
                    n_err++; $display("FAIL b2b t%0d port%0d: got %h want %h", t, i, slot(i), exp);
                end
            end
            cyc();
        end
        idle();
        sel[12] = 3'd1; ren[0] = 4'hF; addr[1] = 11'h205;
        cyc(); idle(); cyc();
        n_vec++; if (slot(0) !== mk(105)) begin n_err++; $display("FAIL b2b_wr_bank12: got %h want %h", slot(0), mk(105)); end
    endtask

    task automatic test_oor();
        logic [EW-1:0] e_pat;
        e_pat = mk(5);
        do_write(6, 11'h000, 4'hF, e_pat);
        sel[6] = 3'd0; addr[0] = 11'h400; tbl1_wen = 4'hF; tbl1_wdata = mk(6);
        n_vec++; if (addr_oor !== 1'b0) begin n_err++; $display("FAIL oor_pre: got %b want 0", addr_oor); end
        cyc(); idle();
        n_vec++; if (addr_oor !== 1'b1) begin n_err++; $display("FAIL oor_wr_pulse: got %b want 1", addr_oor); end
        cyc();
        n_vec++; if (addr_oor !== 1'b0) begin n_err++; $display("FAIL oor_wr_end: got %b want 0", addr_oor); end
        sel[6] = 3'd0; addr[0] = 11'h400; tbl1_wen = 4'h0;
        cyc(); idle();
        n_vec++; if (addr_oor !== 1'b0) begin n_err++; $display("FAIL oor_wen0: got %b want 0", addr_oor); end
        sel[6] = 3'd1; ren[0] = 4'hF; addr[1] = 11'h000;
        cyc(); idle(); cyc();
        n_vec++; if (slot(0) !== e_pat) begin n_err++; $display("FAIL oor_unchanged: got %h want %h", slot(0), e_pat); end
        sel[6] = 3'd1; ren[0] = 4'hF; addr[1] = 11'h400;
        cyc(); idle();
        n_vec++; if (addr_oor !== 1'b1) begin n_err++; $display("FAIL oor_rd_pulse: got %b want 1", addr_oor); end
        cyc();
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL oor_rd_data: got %h want 0", tbl1_rdata); end
    endtask

    task automatic test_reset_mid();
        idle();
        sel[8] = 3'd1; ren[0] = 4'hF; addr[1] = 11'h100;
        cyc();
        addr[1] = 11'h101;
        cyc();
        idle(); rst_n = 1'b0;
        cyc();
        rst_n = 1'b1;
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL rstmid_t0: got %h want 0", tbl1_rdata); end
        n_vec++; if (rd_conflict_cnt !== 16'h0) begin n_err++; $display("FAIL rstmid_cnt: got %h want 0", rd_conflict_cnt); end
        cyc();
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL rstmid_t1: got %h want 0", tbl1_rdata); end
        cyc();
        n_vec++; if (tbl1_rdata !== '0) begin n_err++; $display("FAIL rstmid_t2: got %h want 0", tbl1_rdata); end
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        test_reset();
        test_write_read();
        test_partial_write();
        test_chunk_read();
        test_conflict();
        test_back_to_back();
        test_oor();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
